// File: rtl/axis_pkg.sv
// Shared definitions for the stream-memory front-end blocks: FSM encoding,
// default widths and a grant decode helper.
package axis_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH      = AXIS_DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  function automatic logic [1:0] owner_grant(input logic [1:0] st);
    case (st)
      ST_OWN0: return 2'b01;
      ST_OWN1: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle (data, byte strobes, valid, last, ready) with the
// producer side as master and the consumer side as slave.
interface axis_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (
    output tdata,
    output tstrb,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_out_reg.sv
// Fully registered AXI-Stream output slice: holds the beat while stalled and
// accepts a new beat whenever the register is empty or being drained.
module axis_out_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_strb,
  input  logic                    in_last,
  output logic                    in_ready,
  axis_if.master                  mst
);

  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    last_q;

  assign in_ready = !valid_q || mst.tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
      strb_q  <= in_strb;
      last_q  <= in_last;
    end else if (mst.tready) begin
      valid_q <= 1'b0;
    end
  end

  assign mst.tvalid = valid_q;
  assign mst.tdata  = data_q;
  assign mst.tstrb  = strb_q;
  assign mst.tlast  = last_q;

endmodule

// File: rtl/axis_wr_arbiter.sv
// Two-producer AXI-Stream arbiter in front of the stream memory write port:
// round-robin per packet, registered output, packets truncated at MAX_BEATS.
module axis_wr_arbiter
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BEATS  = 256,
  parameter int unsigned CNT_WIDTH  = 9
) (
  input  logic       axis_aclk,
  input  logic       axis_aresetn,
  axis_if.slave      s00_axis,
  axis_if.slave      s01_axis,
  axis_if.master     m00_axis,
  output logic [1:0] grant,
  output logic       len_err
);

  localparam int unsigned           StrbW   = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(MAX_BEATS - 1);

  logic [1:0]            state_q, state_d;
  logic                  last_owner_q, last_owner_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  len_err_q, len_err_d;
  logic                  src_valid, src_last, tlast_out, out_ready, accept;
  logic [DATA_WIDTH-1:0] src_data;
  logic [StrbW-1:0]      src_strb;

  always_comb begin
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_data  = s00_axis.tdata;
    src_strb  = s00_axis.tstrb;
    case (state_q)
      ST_OWN0: begin
        src_valid = s00_axis.tvalid;
        src_last  = s00_axis.tlast;
      end
      ST_OWN1: begin
        src_valid = s01_axis.tvalid;
        src_last  = s01_axis.tlast;
        src_data  = s01_axis.tdata;
        src_strb  = s01_axis.tstrb;
      end
      default: ;
    endcase
  end

  assign s00_axis.tready = (state_q == ST_OWN0) && out_ready;
  assign s01_axis.tready = (state_q == ST_OWN1) && out_ready;
  assign accept          = src_valid && out_ready;
  assign tlast_out       = src_last || (beat_cnt_q == LastCnt);
  assign grant           = owner_grant(state_q);
  assign len_err         = len_err_q;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    len_err_d    = len_err_q;
    case (state_q)
      ST_IDLE: begin
        // On a tie the source that did not own the last packet wins.
        if (s00_axis.tvalid && s01_axis.tvalid) begin
          state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        end else if (s00_axis.tvalid) begin
          state_d = ST_OWN0;
        end else if (s01_axis.tvalid) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (accept) begin
          if (tlast_out) begin
            state_d      = ST_IDLE;
            last_owner_d = (state_q == ST_OWN1);
            beat_cnt_d   = '0;
            if (!src_last) len_err_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      len_err_q    <= len_err_d;
    end
  end

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk      (axis_aclk),
    .rst_n    (axis_aresetn),
    .in_valid (src_valid),
    .in_data  (src_data),
    .in_strb  (src_strb),
    .in_last  (tlast_out),
    .in_ready (out_ready),
    .mst      (m00_axis)
  );

endmodule
